// File: rtl/pcap_stream_writer.sv
// pcap_stream_writer: turns a framed byte stream into a byte-serial libpcap
// file image. The file image is a 24-byte global header sent once after reset,
// followed by one record per packet. Each record is a 16-byte record header
// and then the captured payload.
// Optional build macro PCAP_NS_TS_EN: nanosecond-resolution pcap.
//   - Magic is written as 4d 3c b2 a1.
//   - The second timestamp field carries nanoseconds instead of microseconds.
//
// state   | meaning
// --------+-------------------------------------------------------------
// GHDR    | emitting the 24-byte global header, input blocked
// IDLE    | waiting for the first byte of a packet
// CAPTURE | storing packet bytes; bytes beyond MAX_PKT are counted, not stored
// RHDR    | emitting the 16-byte record header (sec, frac, incl_len, orig_len)
// PAYLOAD | emitting buffer[0..incl_len-1] from the packet buffer
module pcap_stream_writer #(
   parameter int MAX_PKT       = 2048,
   parameter int CLK_PERIOD_NS = 20,
   parameter int LINKTYPE      = 1
) (
   input  logic       CLOCK,
   input  logic       RESET_N,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   input  logic       in_last,
   output logic       in_ready,
   output logic       out_valid,
   output logic [7:0] out_data,
   input  logic       out_ready,
   output logic [7:0] pktcount,
   output logic       truncated
);

   localparam int AW = $clog2(MAX_PKT);
   // idx must reach both 24 (global header) and MAX_PKT (payload).
   localparam int IW = (AW + 1 > 5) ? AW + 1 : 5;

`ifdef PCAP_NS_TS_EN
   localparam logic [31:0] MAGIC = 32'ha1b23c4d;
`else
   localparam logic [31:0] MAGIC = 32'ha1b2c3d4;
`endif

   typedef enum logic [2:0] {GHDR, IDLE, CAPTURE, RHDR, PAYLOAD} state_t;

   state_t          state;
   logic [IW-1:0]   idx;
   logic [IW-1:0]   wr_cnt;
   logic [AW-1:0]   rd_addr;
   logic [31:0]     orig_len;
   logic [31:0]     orig_nx;
   logic [31:0]     rec_sec;
   logic [31:0]     rec_frac;
   logic [31:0]     rhdr_w;
   logic [31:0]     ts_sec;
   logic [31:0]     ts_frac;
   logic            acc;
   logic            ld;
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [7:0]      mem [MAX_PKT];

`ifdef PCAP_NS_TS_EN
   logic [29:0] ts_ns;
   logic [30:0] ns_sum;

   assign ns_sum  = {1'b0, ts_ns} + 31'(CLK_PERIOD_NS);
   assign ts_frac = {2'b00, ts_ns};

   // free-running ns timestamp, carries into seconds at one billion
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         ts_ns  <= '0;
         ts_sec <= '0;
      end else if (ns_sum >= 31'd1000000000) begin
         ts_ns  <= 30'(ns_sum - 31'd1000000000);
         ts_sec <= ts_sec + 32'd1;
      end else begin
         ts_ns  <= ns_sum[29:0];
      end
   end
`else
   logic [9:0]  sub_ns;
   logic [10:0] sub_sum;
   logic [19:0] ts_usec;

   assign sub_sum = {1'b0, sub_ns} + 11'(CLK_PERIOD_NS);
   assign ts_frac = {12'd0, ts_usec};

   // free-running us timestamp; sub-us ns remainder kept in sub_ns
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         sub_ns  <= '0;
         ts_usec <= '0;
         ts_sec  <= '0;
      end else if (sub_sum >= 11'd1000) begin
         sub_ns <= 10'(sub_sum - 11'd1000);
         if (ts_usec == 20'd999999) begin
            ts_usec <= '0;
            ts_sec  <= ts_sec + 32'd1;
         end else begin
            ts_usec <= ts_usec + 20'd1;
         end
      end else begin
         sub_ns <= sub_sum[9:0];
      end
   end
`endif

   function automatic logic [7:0] le_byte(input logic [31:0] w, input logic [1:0] b);
      case (b)
         2'd0:    return w[7:0];
         2'd1:    return w[15:8];
         2'd2:    return w[23:16];
         default: return w[31:24];
      endcase
   endfunction

   function automatic logic [31:0] ghdr_word(input logic [2:0] w);
      case (w)
         3'd0:    return MAGIC;
         3'd1:    return 32'h00040002;
         3'd4:    return 32'(MAX_PKT);
         3'd5:    return 32'(LINKTYPE);
         default: return 32'd0;
      endcase
   endfunction

   assign acc     = in_valid && in_ready;
   assign ld      = !out_valid || out_ready;
   assign orig_nx = (orig_len == 32'hffffffff) ? orig_len : orig_len + 32'd1;

   // record header word selected by the current header byte index
   always_comb begin
      rhdr_w = orig_len;
      case (idx[3:2])
         2'd0:    rhdr_w = rec_sec;
         2'd1:    rhdr_w = rec_frac;
         2'd2:    rhdr_w = 32'(wr_cnt);
         default: rhdr_w = orig_len;
      endcase
   end

   // buffer write port: first byte goes to address 0, later bytes until full
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = wr_cnt[AW-1:0];
      if (acc && state == IDLE) begin
         wr_en   = 1'b1;
         wr_addr = '0;
      end else if (acc && state == CAPTURE && wr_cnt < IW'(MAX_PKT)) begin
         wr_en = 1'b1;
      end
   end

   // packet buffer storage
   always_ff @(posedge CLOCK) begin
      if (wr_en) mem[wr_addr] <= in_data;
   end

   // sequencing FSM with registered handshake and data outputs
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state     <= GHDR;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         pktcount  <= '0;
         truncated <= 1'b0;
         idx       <= '0;
         wr_cnt    <= '0;
         rd_addr   <= '0;
         orig_len  <= '0;
         rec_sec   <= '0;
         rec_frac  <= '0;
      end else begin
         truncated <= 1'b0;
         case (state)
            GHDR: if (ld) begin
               if (idx < IW'(24)) begin
                  out_valid <= 1'b1;
                  out_data  <= le_byte(ghdr_word(idx[4:2]), idx[1:0]);
                  idx       <= idx + IW'(1);
               end else begin
                  out_valid <= 1'b0;
                  idx       <= '0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            IDLE: if (acc) begin
               rec_sec  <= ts_sec;
               rec_frac <= ts_frac;
               orig_len <= 32'd1;
               wr_cnt   <= IW'(1);
               if (in_last) begin
                  // header byte 0 comes from the live timestamp being latched now
                  in_ready  <= 1'b0;
                  out_valid <= 1'b1;
                  out_data  <= ts_sec[7:0];
                  idx       <= IW'(1);
                  rd_addr   <= '0;
                  state     <= RHDR;
               end else begin
                  state <= CAPTURE;
               end
            end
            CAPTURE: if (acc) begin
               orig_len <= orig_nx;
               if (wr_cnt < IW'(MAX_PKT)) wr_cnt <= wr_cnt + IW'(1);
               if (in_last) begin
                  in_ready  <= 1'b0;
                  out_valid <= 1'b1;
                  out_data  <= rec_sec[7:0];
                  idx       <= IW'(1);
                  rd_addr   <= '0;
                  truncated <= (orig_nx > 32'(MAX_PKT));
                  state     <= RHDR;
               end
            end
            RHDR: if (ld) begin
               if (idx < IW'(16)) begin
                  out_data <= le_byte(rhdr_w, idx[1:0]);
                  idx      <= idx + IW'(1);
               end else begin
                  // first payload byte loads on the edge the last header byte leaves
                  out_data <= mem[rd_addr];
                  rd_addr  <= rd_addr + AW'(1);
                  idx      <= IW'(1);
                  state    <= PAYLOAD;
               end
            end
            PAYLOAD: if (ld) begin
               if (idx < wr_cnt) begin
                  out_data <= mem[rd_addr];
                  rd_addr  <= rd_addr + AW'(1);
                  idx      <= idx + IW'(1);
               end else begin
                  out_valid <= 1'b0;
                  idx       <= '0;
                  pktcount  <= pktcount + 8'd1;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= GHDR;
         endcase
      end
   end

endmodule

// File: tb/tb_pcap_stream_writer.sv
// Bench for pcap_stream_writer: directed sequence with random packet data,
// checked against a file-image model built from cycle time and packet bytes.
`timescale 1ns/1ps
module tb_pcap_stream_writer;

   localparam int MAX_PKT = 64;
   localparam int CLK_NS  = 20;
   localparam int LT      = 1;

   logic       CLOCK = 1'b0;
   logic       RESET_N = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'd0;
   logic       in_last = 1'b0;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready = 1'b1;
   logic [7:0] pktcount;
   logic       truncated;

   pcap_stream_writer #(.MAX_PKT(MAX_PKT), .CLK_PERIOD_NS(CLK_NS), .LINKTYPE(LT)) dut (
      .CLOCK(CLOCK), .RESET_N(RESET_N),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .pktcount(pktcount), .truncated(truncated));

   always #5 CLOCK = ~CLOCK;

   // cycles elapsed since reset release; timestamp = cyc * CLK_NS ns
   int unsigned cyc;
   always @(posedge CLOCK or negedge RESET_N)
      if (!RESET_N) cyc <= 0; else cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;
   int pkts_done = 0;
   int trunc_seen, stall_err, ready_err, bubble_cnt;
   byte unsigned got_q[$];
   byte unsigned exp_q[$];
   byte unsigned pkt[$];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLOCK);
      #1;
   endtask

   function automatic void push_le32(input logic [31:0] w);
      for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
   endfunction

   function automatic void build_ghdr();
      exp_q = {};
`ifdef PCAP_NS_TS_EN
      push_le32(32'ha1b23c4d);
`else
      push_le32(32'ha1b2c3d4);
`endif
      push_le32(32'h00040002);
      push_le32(32'd0);
      push_le32(32'd0);
      push_le32(32'(MAX_PKT));
      push_le32(32'(LT));
   endfunction

   function automatic void build_record(input int unsigned acc_cyc);
      longint unsigned t_ns;
      longint unsigned sec;
      longint unsigned frac;
      int incl;
      t_ns = longint'(acc_cyc) * CLK_NS;
      sec  = t_ns / 64'd1000000000;
`ifdef PCAP_NS_TS_EN
      frac = t_ns % 64'd1000000000;
`else
      frac = (t_ns / 64'd1000) % 64'd1000000;
`endif
      incl = (pkt.size() < MAX_PKT) ? pkt.size() : MAX_PKT;
      exp_q = {};
      push_le32(sec[31:0]);
      push_le32(frac[31:0]);
      push_le32(32'(incl));
      push_le32(32'(pkt.size()));
      for (int i = 0; i < incl; i++) exp_q.push_back(pkt[i]);
   endfunction

   task automatic send_packet(output int unsigned first_cyc, input int gap_max);
      int guard;
      first_cyc = 0;
      for (int i = 0; i < pkt.size(); i++) begin
         in_valid = 1'b0;
         repeat ($urandom_range(0, gap_max)) step();
         in_valid = 1'b1;
         in_data  = pkt[i];
         in_last  = (i == pkt.size() - 1);
         guard = 0;
         while (in_ready !== 1'b1 && guard < 2000) begin
            step();
            guard++;
         end
         if (guard >= 2000) chk("in_ready_wait", in_ready, 1);
         if (i == 0) first_cyc = cyc;
         step();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // mode 0: out_ready=1, mode 1: toggle every cycle, mode 2: random
   task automatic collect(input int n, input int mode);
      int guard;
      bit held_v;
      logic [7:0] held;
      got_q = {};
      trunc_seen = 0; stall_err = 0; ready_err = 0; bubble_cnt = 0;
      held_v = 0; held = 0; guard = 0;
      out_ready = 1'b1;
      while (got_q.size() < n && guard < 4000) begin
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         if (held_v && (out_valid !== 1'b1 || out_data !== held)) stall_err++;
         if (in_ready !== 1'b0) ready_err++;
         if (truncated === 1'b1) trunc_seen++;
         held_v = 0;
         if (out_valid === 1'b1 && out_ready) got_q.push_back(out_data);
         else if (out_valid === 1'b1) begin held_v = 1; held = out_data; end
         else if (got_q.size() > 0) bubble_cnt++;
         step();
         guard++;
      end
      out_ready = 1'b1;
      chk("byte_count", got_q.size(), n);
   endtask

   task automatic compare_bytes(input string tag, input int n);
      for (int i = 0; i < n && i < got_q.size(); i++)
         chk($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
   endtask

   task automatic check_ghdr();
      build_ghdr();
      collect(24, 0);
      compare_bytes("ghdr", 24);
      chk("ghdr_bubbles", bubble_cnt, 0);
      chk("ghdr_ready_low", ready_err, 0);
      chk("ghdr_then_ready", in_ready, 1);
   endtask

   task automatic run_packet(input string tag, input int len, input int gap_max,
                             input int mode, input bit ramp);
      int unsigned c0;
      int incl;
      pkt = {};
      for (int i = 0; i < len; i++) pkt.push_back(ramp ? 8'(i) : 8'($urandom_range(0, 255)));
      send_packet(c0, gap_max);
      build_record(c0);
      incl = (len < MAX_PKT) ? len : MAX_PKT;
      chk({tag, "_hdr_latency"}, out_valid, 1);
      chk({tag, "_trunc_first"}, truncated, (len > MAX_PKT));
      collect(16 + incl, mode);
      compare_bytes(tag, 16 + incl);
      pkts_done++;
      chk({tag, "_pktcount"}, pktcount, 32'(pkts_done % 256));
      chk({tag, "_ready_after"}, in_ready, 1);
      chk({tag, "_trunc_pulses"}, trunc_seen, (len > MAX_PKT) ? 1 : 0);
      chk({tag, "_stall_hold"}, stall_err, 0);
      chk({tag, "_ready_low"}, ready_err, 0);
      chk({tag, "_bubbles"}, bubble_cnt, 0);
   endtask

   initial begin
      int unsigned c0;
      RESET_N = 1'b0;
      repeat (3) @(posedge CLOCK);
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_pktcount", pktcount, 0);
      chk("rst_truncated", truncated, 0);
      RESET_N = 1'b1;

      check_ghdr();

      // first byte accepted 50 cycles after timestamp reset
      while (cyc < 50) step();
      run_packet("basic60", 60, 0, 0, 1'b1);
      run_packet("trunc100", 100, 1, 0, 1'b0);
      run_packet("bp_toggle", 40 + int'($urandom_range(0, 30)), 0, 1, 1'b0);
      run_packet("one_byte", 1, 2, 2, 1'b0);
      run_packet("exact_max", MAX_PKT, 1, 2, 1'b0);
      run_packet("max_plus1", MAX_PKT + 1, 0, 1, 1'b0);
      for (int k = 0; k < 6; k++)
         run_packet($sformatf("rand%0d", k), int'($urandom_range(1, 130)), 2, 2, 1'b0);

      // reset at payload byte 10
      pkt = {};
      for (int i = 0; i < 40; i++) pkt.push_back(8'($urandom_range(0, 255)));
      send_packet(c0, 0);
      build_record(c0);
      collect(26, 0);
      compare_bytes("pre_reset", 26);
      RESET_N = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      chk("mid_rst_out_data", out_data, 0);
      chk("mid_rst_pktcount", pktcount, 0);
      chk("mid_rst_truncated", truncated, 0);
      @(posedge CLOCK);
      @(posedge CLOCK);
      #1;
      RESET_N = 1'b1;
      pkts_done = 0;
      check_ghdr();
      chk("post_rst_pktcount", pktcount, 0);
      run_packet("post_rst", 5, 1, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pcap_stream_writer.md
Name: pcap_stream_writer

Overview:
- Inverse of the pcap replay parser: accepts a framed byte stream and emits a byte-serial, libpcap-format file image.
- Emits a 24-byte global header once after reset, then per packet a 16-byte record header followed by the payload.
- Used to capture datapath output into pcap files in simulation, and as an on-chip capture formatter.

Parameters:
- MAX_PKT, 2048: packet buffer depth in bytes; also the snaplen written to the global header; power of two.
- CLK_PERIOD_NS, 20: ns added to the timestamp per CLOCK cycle; range 1..999.
- LINKTYPE, 1: network field of the global header (1 = Ethernet).

Ports:
- CLOCK  in  1  single clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- in_valid  in  1  input byte present.
- in_data  in  8  input byte.
- in_last  in  1  qualifies the final byte of a packet.
- in_ready  out  1  writer accepts a byte this cycle.
- out_valid  out  1  output byte present.
- out_data  out  8  output pcap byte.
- out_ready  in  1  downstream accepts a byte.
- pktcount  out  8  records fully emitted, mod 256.
- truncated  out  1  one-cycle pulse when a record with incl_len < orig_len starts emission.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, pktcount=0, truncated=0, state=GHDR, timestamp=0.
- Reset asserted mid-operation: discard the buffer, return to GHDR; the global header is re-emitted after release.
- Handshakes:
  - Input byte transfers when in_valid && in_ready.
  - Output byte transfers when out_valid && out_ready.
  - While out_valid && !out_ready, out_data and out_valid hold stable.
  - Outputs are registered.
- Multi-byte fields are little-endian (LSB first).
- Global header byte order: magic d4 c3 b2 a1, version 02 00 04 00, thiszone 0 (4 bytes), sigfigs 0 (4 bytes), snaplen = MAX_PKT (4 bytes), network = LINKTYPE (4 bytes).
- Timestamp:
  - Free-running sec[31:0] and usec[19:0].
  - An ns sub-accumulator adds CLK_PERIOD_NS each cycle. At >=1000 it subtracts 1000 and increments usec.
  - usec wraps 999999->0 and increments sec. sec wraps at 2^32.
- States:
  - GHDR: in_ready=0; emit 24 bytes; after the last byte transfers -> IDLE.
  - IDLE: in_ready=1. On an accepted byte: write it to buffer[0], latch sec/usec of that cycle, set len=1. If in_last -> RHDR, else -> CAPTURE.
  - CAPTURE: in_ready=1.
    - Each accepted byte increments orig_len (32-bit, saturating).
    - The byte is stored only while stored count < MAX_PKT; excess bytes are accepted and dropped.
    - in_last -> RHDR.
  - RHDR: in_ready=0.
    - Emit ts_sec (4 bytes), ts_usec (4), incl_len = min(orig_len, MAX_PKT) (4), orig_len (4).
    - truncated pulses on the cycle the first record header byte is presented, if incl_len < orig_len.
    - After 16 bytes -> PAYLOAD.
  - PAYLOAD: in_ready=0.
    - Emit buffer[0..incl_len-1].
    - After the last byte transfers: pktcount++ (wraps 255->0), then -> IDLE.
- Latency: first record header byte is valid on the cycle after in_last is accepted.
- A 1-byte packet (in_last on the first byte) is legal: incl_len=orig_len=1.
- No back-to-back overlap: a new packet is not accepted until the previous payload has drained.
- Buffer is a single-port RAM inferred for reads. Read address is registered so the next byte is ready for back-to-back transfers with out_ready=1: one byte per cycle, no bubbles.

Optional Feature:
- Macro: PCAP_NS_TS_EN.
- Defined:
  - Nanosecond-resolution pcap: magic bytes 4d 3c b2 a1.
  - Second timestamp field carries ns[29:0] (0..999999999), advancing by CLK_PERIOD_NS per cycle and wrapping into sec.
- Undefined: microsecond format exactly as above.

Test Plan:
- Global header: release reset with out_ready=1 -> 24 bytes d4 c3 b2 a1 02 00 04 00, 8 x 00, 00 08 00 00, 01 00 00 00 on consecutive cycles; then in_ready=1.
- Basic record: send a 60-byte packet 0x00..0x3B -> 16-byte header with incl_len=orig_len=3c 00 00 00, then payload 0x00..0x3B; pktcount=1.
- Truncation: MAX_PKT=64, send 100 bytes -> incl_len=40 00 00 00, orig_len=64 00 00 00, 64 payload bytes, truncated pulses once.
- Timestamp: CLK_PERIOD_NS=20; first packet byte accepted 50 cycles after timestamp reset -> ts_usec=01 00 00 00, ts_sec=0. With PCAP_NS_TS_EN: ns field = e8 03 00 00.
- Backpressure: toggle out_ready every cycle during RHDR/PAYLOAD -> out_data stable while stalled, byte sequence identical to the unstalled run, in_ready=0 throughout.
- Reset mid-payload: assert RESET_N=0 at payload byte 10 -> outputs return to reset values at once. After release, the global header is re-emitted, pktcount=0, and no residue of the old packet appears.
